// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - pipe scrolling, respawn, scoring and IDLE/RUN/DEAD game state
//
// Ports:
//   i_frame_clk   frame-rate clock, one rising edge per vsync
//   i_reset       asynchronous active-high reset
//   i_start       flap/start key level; only its rising edge acts
//   i_collide     bird hit a pipe or the ground this frame (level)
//   o_pipe_x      pipe i left-edge X at [10*i +: 10]
//   o_gap_y       pipe i gap-centre Y at [10*i +: 10]
//   o_score       scored passes, saturating at 16'hFFFF
//   o_speed       current scroll step in pixels/frame
//   o_game_state  00 IDLE, 01 RUN, 10 DEAD
module pipe_scheduler #(
    parameter int NUM_PIPES  = 3,
    parameter int X_START    = 640,
    parameter int SPACING    = 220,
    parameter int BIRD_X     = 160,
    parameter int GAP_MIN    = 120,
    parameter int BASE_SPEED = 1,
    parameter int MAX_SPEED  = 4,
    parameter int SPEED_STEP = 10
) (
    input  logic                      i_frame_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_collide,
    output logic [NUM_PIPES*10-1:0]   o_pipe_x,
    output logic [NUM_PIPES*10-1:0]   o_gap_y,
    output logic [15:0]               o_score,
    output logic [3:0]                o_speed,
    output logic [1:0]                o_game_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    localparam logic [9:0] LP_RING     = 10'(NUM_PIPES * SPACING);
    localparam logic [9:0] LP_BIRD     = 10'(BIRD_X);
    localparam logic [9:0] LP_GAP_MIN  = 10'(GAP_MIN);
    localparam logic [9:0] LP_GAP_IDLE = 10'(GAP_MIN + 64);
    localparam logic [3:0] LP_BASE     = 4'(BASE_SPEED);
    localparam logic [3:0] LP_MAX      = 4'(MAX_SPEED);
    localparam logic [7:0] LP_STEP     = 8'(SPEED_STEP);

    state_t     r_state;
    logic [9:0] r_pipe_x [NUM_PIPES];
    logic [9:0] r_gap_y  [NUM_PIPES];
    logic [15:0] r_score;
    logic [3:0] r_speed;
    logic [7:0] r_step;
    logic [7:0] r_lfsr;
    logic       r_start_q;

    logic                 w_start_rise;
    logic [7:0]           w_lfsr_next;
    logic [9:0]           w_spd;
    logic [9:0]           w_new_x [NUM_PIPES];
    logic [NUM_PIPES-1:0] w_wrap;
    logic [NUM_PIPES-1:0] w_pass;
    logic [2:0]           w_passes;
    logic [16:0]          w_score_sum;
    logic [7:0]           w_step_sum;

    assign w_start_rise = i_start & ~r_start_q;
    // Fibonacci form of x^8+x^6+x^5+x^4+1; a nonzero seed never reaches zero
    assign w_lfsr_next  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_spd        = {6'd0, r_speed};

    always_comb begin
        w_new_x  = '{default: '0};
        w_wrap   = '0;
        w_pass   = '0;
        w_passes = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (r_pipe_x[i] > w_spd) begin
                w_new_x[i] = r_pipe_x[i] - w_spd;
            end else begin
                // Respawn one full ring to the right so spacing stays exact
                w_new_x[i] = r_pipe_x[i] + LP_RING - w_spd;
                w_wrap[i]  = 1'b1;
            end
            w_pass[i] = (r_pipe_x[i] >= LP_BIRD) && (w_new_x[i] < LP_BIRD);
            w_passes  = w_passes + {2'b00, w_pass[i]};
        end
    end

    assign w_score_sum = {1'b0, r_score} + {14'd0, w_passes};
    assign w_step_sum  = r_step + {5'd0, w_passes};

    always_ff @(posedge i_frame_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lfsr    <= 8'hA5;
            r_start_q <= 1'b0;
            r_state   <= ST_IDLE;
            r_score   <= '0;
            r_speed   <= LP_BASE;
            r_step    <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_pipe_x[i] <= 10'(X_START + i * SPACING);
                r_gap_y[i]  <= LP_GAP_IDLE;
            end
        end else begin
            r_lfsr    <= w_lfsr_next;
            r_start_q <= i_start;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (i_collide) begin
                        r_state <= ST_DEAD;
                    end else begin
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            r_pipe_x[i] <= w_new_x[i];
                            if (w_wrap[i]) r_gap_y[i] <= LP_GAP_MIN + {3'd0, r_lfsr[6:0]};
                        end
                        r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                        if (w_step_sum >= LP_STEP) begin
                            r_step <= w_step_sum - LP_STEP;
                            if (r_speed < LP_MAX) r_speed <= r_speed + 4'd1;
                        end else begin
                            r_step <= w_step_sum;
                        end
                    end
                end
                default: begin
                    // DEAD holds everything; an unused encoding falls back to IDLE
                    if (w_start_rise || (r_state != ST_DEAD)) begin
                        r_state <= ST_IDLE;
                        r_score <= '0;
                        r_speed <= LP_BASE;
                        r_step  <= '0;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            r_pipe_x[i] <= 10'(X_START + i * SPACING);
                            r_gap_y[i]  <= LP_GAP_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PIPES; g++) begin : g_pack
            assign o_pipe_x[10*g +: 10] = r_pipe_x[g];
            assign o_gap_y[10*g +: 10]  = r_gap_y[g];
        end
    endgenerate

    assign o_score      = r_score;
    assign o_speed      = r_speed;
    assign o_game_state = r_state;

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb/tb_pipe_scheduler.sv - scoreboard bench for pipe_scheduler
module tb_pipe_scheduler;

    localparam int NP = 3;
    localparam int SS = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          collide;
    logic [29:0]   pipe_x;
    logic [29:0]   gap_y;
    logic [15:0]   score;
    logic [3:0]    speed;
    logic [1:0]    state;

    pipe_scheduler #(
        .NUM_PIPES(NP), .X_START(640), .SPACING(220), .BIRD_X(160), .GAP_MIN(120),
        .BASE_SPEED(1), .MAX_SPEED(4), .SPEED_STEP(SS)
    ) dut (
        .i_frame_clk(clk), .i_reset(rst), .i_start(start), .i_collide(collide),
        .o_pipe_x(pipe_x), .o_gap_y(gap_y), .o_score(score), .o_speed(speed),
        .o_game_state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [29:0] px;
        logic [29:0] gy;
        logic [15:0] sc;
        logic [3:0]  sp;
        logic [1:0]  st;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model, plain integer arithmetic with explicit mod-1024 wrap
    int         m_x [NP];
    int         m_gap [NP];
    int         m_score, m_speed, m_step, m_state;
    logic [7:0] m_lfsr;
    logic       m_start_q;

    function automatic void m_idle();
        for (int i = 0; i < NP; i++) begin
            m_x[i]   = (640 + i * 220) % 1024;
            m_gap[i] = 184;
        end
        m_score = 0; m_speed = 1; m_step = 0; m_state = 0;
    endfunction

    function automatic void m_reset();
        m_idle();
        m_lfsr    = 8'hA5;
        m_start_q = 1'b0;
    endfunction

    function automatic exp_t m_snap();
        exp_t e;
        for (int i = 0; i < NP; i++) begin
            e.px[10*i +: 10] = 10'(m_x[i]);
            e.gy[10*i +: 10] = 10'(m_gap[i]);
        end
        e.sc = 16'(m_score);
        e.sp = 4'(m_speed);
        e.st = 2'(m_state);
        return e;
    endfunction

    function automatic void m_frame(input logic st, input logic col);
        logic rise;
        int   passes, nx;
        rise = st && !m_start_q;
        if (m_state == 0) begin
            if (rise) m_state = 1;
        end else if (m_state == 1) begin
            if (col) begin
                m_state = 2;
            end else begin
                passes = 0;
                for (int i = 0; i < NP; i++) begin
                    if (m_x[i] > m_speed) begin
                        nx = m_x[i] - m_speed;
                    end else begin
                        nx = (m_x[i] + 660 - m_speed) % 1024;
                        m_gap[i] = 120 + int'(m_lfsr & 8'h7F);
                    end
                    if (m_x[i] >= 160 && nx < 160) passes++;
                    m_x[i] = nx;
                end
                m_score = (m_score + passes > 65535) ? 65535 : m_score + passes;
                m_step  = m_step + passes;
                if (m_step >= SS) begin
                    m_step  = m_step - SS;
                    m_speed = (m_speed + 1 > 4) ? 4 : m_speed + 1;
                end
            end
        end else begin
            if (rise) m_idle();
        end
        m_start_q = st;
        m_lfsr    = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endfunction

    task automatic frame(input logic st, input logic col);
        exp_t e;
        start   = st;
        collide = col;
        m_frame(st, col);
        sb_q.push_back(m_snap());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check("pipe_x", 64'(pipe_x), 64'(e.px));
            check("gap_y",  64'(gap_y),  64'(e.gy));
            check("score",  64'(score),  64'(e.sc));
            check("speed",  64'(speed),  64'(e.sp));
            check("state",  64'(state),  64'(e.st));
        end
    endtask

    // Idle/reset constants; pipe 2 parks at 1080, which is 56 in 10 bits
    task automatic check_idle(input string tag);
        check({tag, "_px"},    64'(pipe_x), 64'({10'd56, 10'd860, 10'd640}));
        check({tag, "_gy"},    64'(gap_y),  64'({10'd184, 10'd184, 10'd184}));
        check({tag, "_score"}, 64'(score),  64'd0);
        check({tag, "_speed"}, 64'(speed),  64'd1);
        check({tag, "_state"}, 64'(state),  64'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; collide = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_idle("reset_async");
        @(posedge clk);
        #1 rst = 1'b0;
        m_reset();

        // IDLE -> RUN; start held high afterwards must not retrigger
        frame(1'b1, 1'b0);
        check("enter_run_noshift", 64'(pipe_x[9:0]), 64'd640);
        for (int k = 0; k < 10; k++) frame(1'b1, 1'b0);
        check("run_state", 64'(state), 64'd1);
        check("p0_after10", 64'(pipe_x[9:0]), 64'd630);
        check("p1_after10", 64'(pipe_x[19:10]), 64'd850);

        for (int k = 0; k < 470; k++) frame(1'b0, 1'b0);
        check("p0_at_bird", 64'(pipe_x[9:0]), 64'd160);
        check("score_before_pass", 64'(score), 64'd0);
        frame(1'b0, 1'b0);
        check("p0_past_bird", 64'(pipe_x[9:0]), 64'd159);
        check("score_first_pass", 64'(score), 64'd1);

        // Long run with start noise: wraps, LFSR gaps, speed steps and ceiling
        for (int k = 0; k < 2500; k++) frame(1'($urandom_range(0, 1)), 1'b0);
        check("speed_ceiling", 64'(speed), 64'd4);

        // Collide beats start; DEAD freezes with start held high
        frame(1'b0, 1'b0);
        frame(1'b1, 1'b1);
        check("dead_state", 64'(state), 64'd2);
        for (int k = 0; k < 20; k++) frame(1'b1, 1'($urandom_range(0, 1)));
        frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        check_idle("dead_to_idle");

        // New game: LFSR has continued, so respawn gaps follow the model sequence
        frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        for (int k = 0; k < 700; k++) frame(1'b0, 1'b0);

        // Asynchronous reset mid-RUN
        #2 rst = 1'b1;
        #1 check_idle("reset_mid_run");
        @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
        sb_q.delete();
        for (int k = 0; k < 5; k++) frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        for (int k = 0; k < 60; k++) frame(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
